// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared definitions for the 8-way round-robin arbiter.
//   N_REQ       : number of requesters
//   ID_W        : width of a binary requester index
//   arb_state_e : arbiter FSM states
package rr_arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned ID_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle between requesters and the arbiter.
//   req       : per-requester request, bit i is requester i
//   done      : current grantee releases the resource
//   gnt       : one-hot grant, zero when nothing is granted
//   gnt_id    : binary index of the grantee, zero when gnt_valid=0
//   gnt_valid : high exactly when gnt is non-zero
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter8_if;
    import rr_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_valid;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_id,
        input  gnt_valid
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_id,
        output gnt_valid
    );

endinterface

// File: rtl/rr_arbiter8_decoder3to8.sv
// decoder3to8: 3-to-8 one-hot decoder with enable.
//   sel_i : binary select
//   en_i  : enable; output is all-zero when low
//   dec_o : one-hot output
module decoder3to8 (
    input  logic [2:0] sel_i,
    input  logic       en_i,
    output logic [7:0] dec_o
);

    always_comb begin
        dec_o = '0;
        if (en_i) begin
            dec_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with a two-state IDLE/GRANT FSM.
// All outputs are registered; a grant is issued one edge after the request
// is seen in IDLE and held until done, request drop or (optionally) timeout.
// After every release the search pointer moves to the grantee's index + 1.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : rr_arbiter8_if.slave (req, done in; gnt, gnt_id, gnt_valid out)
// Parameter TIMEOUT (2..255): maximum grant length in cycles, used only
// when the macro RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    rr_arbiter8_if.slave     bus
);

    // Reject out-of-range hold limits at elaboration.
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("rr_arbiter8: TIMEOUT must be in 2..255");
    end

    // First set bit of r searching upward from p, wrapping modulo N_REQ.
    // {r, r} rotated by p puts requester p at bit 0, so the lowest set bit
    // of the rotated vector is the offset from p.
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [N_REQ-1:0] r,
        input logic [ID_W-1:0]  p
    );
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [ID_W-1:0]    off;
        logic               found;
        dbl   = {r, r};
        rot   = dbl[p +: N_REQ];
        off   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (rot[i] && !found) begin
                off   = ID_W'(i);
                found = 1'b1;
            end
        end
        return p + off;
    endfunction

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             release_w;
    logic             timeout_w;

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0]       timer_q, timer_d;
    assign timeout_w = (timer_q == 8'(TIMEOUT - 1));
`else
    assign timeout_w = 1'b0;
`endif

    // done has priority only in name: every release source has the same effect.
    assign release_w = bus.done || !bus.req[gnt_id_q] || timeout_w;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
`ifdef RR_ARB_TIMEOUT_EN
        timer_d     = timer_q;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    gnt_id_d    = rr_pick(bus.req, ptr_q);
                    gnt_valid_d = 1'b1;
                    state_d     = GRANT;
`ifdef RR_ARB_TIMEOUT_EN
                    timer_d     = '0;
`endif
                end else begin
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (release_w) begin
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_id_q + ID_W'(1);
                    state_d     = IDLE;
                end
`ifdef RR_ARB_TIMEOUT_EN
                else begin
                    timer_d = timer_q + 8'd1;
                end
`endif
            end
            default: begin
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // One-hot grant is decoded from the next-state index so gnt is a register.
    decoder3to8 u_dec (
        .sel_i (gnt_id_d),
        .en_i  (gnt_valid_d),
        .dec_o (gnt_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            gnt_q       <= '0;
`ifdef RR_ARB_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_q       <= gnt_d;
`ifdef RR_ARB_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: self-checking bench for rr_arbiter8 (TIMEOUT=4).
// Directed vector table, hand-written timeout and mid-grant reset sequences,
// then randomized traffic against a queue-free behavioural model.
module tb_rr_arbiter8;
    import rr_arb_pkg::*;

    localparam int unsigned TO = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    rr_arbiter8_if bus();

    rr_arbiter8 #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic       v;
        int         id;
        string      name;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: who holds the grant, how long, and where search starts.
    bit m_busy;
    int m_id;
    int m_ptr;
    int m_len;

    function automatic logic [7:0] onehot(input bit v, input int id);
        logic [7:0] one;
        one = 8'h01;
        return v ? (one << id) : 8'h00;
    endfunction

    function automatic void add(input logic r, input logic [7:0] q, input logic d,
                                input logic v, input int id, input string n);
        vec_t e;
        e.rst = r; e.req = q; e.done = d; e.v = v; e.id = id; e.name = n;
        vecs.push_back(e);
    endfunction

    task automatic check(input string name, input logic [7:0] eg,
                         input logic [2:0] eid, input logic ev);
        checks++;
        if (bus.gnt !== eg || bus.gnt_id !== eid || bus.gnt_valid !== ev) begin
            errors++;
            $display("FAIL %s: got gnt=%h id=%0d valid=%b, want gnt=%h id=%0d valid=%b",
                     name, bus.gnt, bus.gnt_id, bus.gnt_valid, eg, eid, ev);
        end
    endtask

    task automatic check_exp(input string name, input bit v, input int id);
        check(name, onehot(v, id), v ? 3'(id) : 3'd0, v);
    endtask

    task automatic step(input logic [7:0] r, input logic d);
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic void model_reset();
        m_busy = 1'b0;
        m_id   = 0;
        m_ptr  = 0;
        m_len  = 0;
    endfunction

    function automatic void model_edge(input logic [7:0] r, input logic d);
        if (!m_busy) begin
            if (r != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (r[(m_ptr + k) % 8]) begin
                        m_id = (m_ptr + k) % 8;
                        break;
                    end
                end
                m_busy = 1'b1;
                m_len  = 1;
            end
        end else if (d || !r[m_id] || (TO_EN && m_len >= TO)) begin
            m_busy = 1'b0;
            m_ptr  = (m_id + 1) % 8;
        end else begin
            m_len++;
        end
    endfunction

    initial begin
        logic [7:0] rq;
        logic       dn;

        rst      = 1'b1;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        #1;
        check_exp("reset_outputs", 1'b0, 0);

        // Basic grant/release, done ignored in IDLE.
        add(1, 8'h00, 0, 0, 0, "reset");
        add(0, 8'h01, 0, 1, 0, "first_grant");
        add(0, 8'h01, 1, 0, 0, "done_release");
        add(0, 8'h00, 1, 0, 0, "idle_done_ignored");
        // Rotation with done held: grant every other cycle, ids 0..7,0.
        add(1, 8'h00, 0, 0, 0, "reset");
        for (int k = 0; k < 17; k++) begin
            add(0, 8'hFF, 1, (k % 2) == 0, (k / 2) % 8, "rotate");
        end
        // Wrap and skip.
        add(1, 8'h00, 0, 0, 0, "reset");
        add(0, 8'h40, 0, 1, 6, "grant6");
        add(0, 8'h40, 1, 0, 0, "release6");
        add(0, 8'h41, 0, 1, 0, "wrap_to0");
        add(0, 8'h41, 1, 0, 0, "release0");
        add(0, 8'h40, 0, 1, 6, "skip_to6");
        add(0, 8'h40, 1, 0, 0, "release6b");
        // Request drop releases and moves the pointer to 4.
        add(0, 8'h08, 0, 1, 3, "grant3");
        add(0, 8'hF8, 0, 1, 3, "hold_ignores_others");
        add(0, 8'hF0, 0, 0, 0, "req_drop_release");
        add(0, 8'h18, 0, 1, 4, "ptr_after_drop");
        add(0, 8'h18, 1, 0, 0, "release4");

        for (int i = 0; i < vecs.size(); i++) begin
            rst      = vecs[i].rst;
            bus.req  = vecs[i].req;
            bus.done = vecs[i].done;
            @(posedge clk);
            #1;
            rst = 1'b0;
            check_exp(vecs[i].name, vecs[i].v, vecs[i].id);
        end

        // Timeout: req 7 held, no done.
        pulse_reset();
        if (TO_EN) begin
            for (int k = 0; k < 4; k++) begin
                step(8'h80, 1'b0);
                check_exp("timeout_hold", 1'b1, 7);
            end
            step(8'h80, 1'b0);
            check_exp("timeout_idle", 1'b0, 0);
            step(8'h80, 1'b0);
            check_exp("timeout_regrant", 1'b1, 7);
        end else begin
            for (int k = 0; k < 101; k++) begin
                step(8'h80, 1'b0);
                check_exp("no_timeout_hold", 1'b1, 7);
            end
        end

        // Asynchronous reset in the middle of a grant.
        pulse_reset();
        step(8'h20, 1'b0);
        check_exp("grant5", 1'b1, 5);
        #2;
        rst = 1'b1;
        #1;
        check_exp("async_reset_clears", 1'b0, 0);
        @(posedge clk);
        #1;
        check_exp("reset_held", 1'b0, 0);
        rst = 1'b0;
        step(8'h21, 1'b0);
        check_exp("after_reset_ptr0", 1'b1, 0);
        step(8'h21, 1'b1);
        check_exp("after_reset_release", 1'b0, 0);

        // Randomized traffic against the model.
        pulse_reset();
        model_reset();
        rq = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                check_exp("rand_async_reset", 1'b0, 0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                model_reset();
            end
            if ($urandom_range(0, 3) == 0) begin
                rq = 8'($urandom & $urandom);
            end
            dn = ($urandom_range(0, 5) == 0);
            bus.req  = rq;
            bus.done = dn;
            @(posedge clk);
            model_edge(rq, dn);
            #1;
            check_exp("random", m_busy, m_id);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
